// File: rtl/aes_iter_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES controller.
// Byte 0 of a 128-bit state sits in bits [127:120]; column c holds bytes 4c..4c+3.
package aes_iter_pkg;

  localparam int unsigned AES_BLK_W = 128;
  // Largest round-key count (AES-256: 14 rounds + initial key).
  localparam int unsigned MaxRk     = 15;
  localparam int unsigned AllRkW    = AES_BLK_W * MaxRk;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } aes_st_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] m;
    p = '0;
    x = a;
    m = b;
    for (int i = 0; i < 8; i++) begin
      if (m[0]) p = p ^ x;
      x = xtime(x);
      m = m >> 1;
    end
    return p;
  endfunction

  // S-box computed as the affine map of the field inverse a^254 (0 maps to 0).
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);  // a^127
    r = gf_mul(r, r);                                          // a^254
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
             ^ 8'h63;
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] s, input int unsigned idx);
    return 8'(s >> (8 * (15 - idx)));
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++) o = {o[119:0], sbox(get_byte(s, i))};
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      o = {o[119:0], get_byte(s, 4 * (((k / 4) + (k % 4)) % 4) + (k % 4))};
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = get_byte(s, 4 * c);
      a1 = get_byte(s, 4 * c + 1);
      a2 = get_byte(s, 4 * c + 2);
      a3 = get_byte(s, 4 * c + 3);
      o = {o[95:0],
           xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  // Round key r of nr+1 keys packed with key 0 uppermost in the low 128*(nr+1) bits.
  function automatic logic [AES_BLK_W-1:0] rk_sel(input logic [AllRkW-1:0] all_rk,
                                                   input int unsigned nr,
                                                   input int unsigned r);
    return AES_BLK_W'(all_rk >> (AES_BLK_W * (nr - r)));
  endfunction

endpackage

// File: rtl/aes_iter_round_unit.sv
// Shared AES round datapath: full encrypt round, or final round without MixColumns.
module aes_round_unit
  import aes_iter_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         last_i,
  output logic [127:0] state_o
);

  logic [127:0] sr;

  // SubBytes -> ShiftRows -> (MixColumns unless last) -> AddRoundKey
  always_comb begin
    sr      = shift_rows(sub_bytes(state_i));
    state_o = (last_i ? sr : mix_columns(sr)) ^ rk_i;
  end

endmodule

// File: rtl/aes_iter_ctrl.sv
// Iterative AES encryption controller: one round per clock through a shared datapath.
// Optional macro AES_ITER_OVERLAP_EN lets a new block be accepted on the same edge the
// finished ciphertext retires.
module aes_iter_ctrl #(
  parameter int unsigned N  = 128,
  parameter int unsigned Nr = 10,
  parameter int unsigned Nk = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   in_data,
  input  logic [N-1:0]   key,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out_data,
  output logic           busy
);
  import aes_iter_pkg::*;

  localparam int unsigned RndW     = $clog2(Nr + 1);
  localparam int unsigned NumWords = 4 * (Nr + 1);
  localparam int unsigned WfW      = 32 * NumWords;

  aes_st_e        state_q, state_d;
  logic [RndW-1:0] rnd_q, rnd_d;
  logic [127:0]   st_q, st_d;
  logic [N-1:0]   key_q, key_d;

  logic [WfW-1:0]    w_flat;
  logic [AllRkW-1:0] rk_all;
  logic [127:0]      rk_cur;
  logic [127:0]      round_out;
  logic              rnd_last;

  // Key schedule from the latched key; word 0 ends up in the top bits of w_flat.
  always_comb begin
    logic [31:0] tmp;
    logic [31:0] back;
    logic [7:0]  rcon;
    w_flat = '0;
    rcon   = 8'h01;
    tmp    = '0;
    back   = '0;
    for (int unsigned i = 0; i < Nk; i++) begin
      w_flat = w_flat | (WfW'(32'(key_q >> (N - 32 * (i + 1)))) << (32 * (NumWords - 1 - i)));
    end
    for (int unsigned i = Nk; i < NumWords; i++) begin
      tmp  = 32'(w_flat >> (32 * (NumWords - i)));
      back = 32'(w_flat >> (32 * (NumWords - 1 - i + Nk)));
      if (i % Nk == 0) begin
        tmp  = sub_word(rot_word(tmp)) ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end else if (Nk > 6 && i % Nk == 4) begin
        tmp = sub_word(tmp);
      end
      w_flat = w_flat | (WfW'(back ^ tmp) << (32 * (NumWords - 1 - i)));
    end
  end

  assign rk_all   = AllRkW'(w_flat);
  assign rk_cur   = rk_sel(rk_all, Nr, 32'(rnd_q));
  assign rnd_last = (rnd_q == RndW'(Nr));

  aes_round_unit u_round (
    .state_i (st_q),
    .rk_i    (rk_cur),
    .last_i  (rnd_last),
    .state_o (round_out)
  );

  // Next-state, datapath load and handshake decode.
  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    st_d      = st_q;
    key_d     = key_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: in_ready = 1'b1;
      StRun: begin
        st_d = round_out;
        if (rnd_last) state_d = StDone;
        else          rnd_d   = rnd_q + RndW'(1);
      end
      StDone: begin
        out_valid = 1'b1;
`ifdef AES_ITER_OVERLAP_EN
        in_ready  = out_ready;
`endif
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Round key 0 is the top 128 key bits, so the whitening needs no expansion.
    if (in_valid && in_ready) begin
      key_d   = key;
      st_d    = in_data ^ key[N-1 -: AES_BLK_W];
      rnd_d   = RndW'(1);
      state_d = StRun;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rnd_q   <= '0;
      st_q    <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      key_q   <= key_d;
    end
  end

  assign out_data = st_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Self-checking bench for aes_iter_ctrl (AES-128 and AES-256 instances).
module tb_aes_iter_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data, out_data, key;

  logic         in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [127:0] in_data2, out_data2;
  logic [255:0] key2;

  aes_iter_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  aes_iter_ctrl #(.N(256), .Nr(14), .Nk(8)) dut256 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .in_data   (in_data2),
    .key       (key2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out_data  (out_data2),
    .busy      (busy2)
  );

`ifdef AES_ITER_OVERLAP_EN
  localparam int Spacing = 11;
`else
  localparam int Spacing = 12;
`endif

  typedef struct packed {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [3];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Wait (bounded) for out_valid on the 128-bit instance; returns cycles waited.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
      key     = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
  endtask

  // One full transaction; inputs are scrambled and in_valid offered while busy.
  task automatic run_block(input vec_t v, input string tag);
    int n;
    @(negedge clk);
    chk({tag, " in_ready idle"}, 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    key      = v.key;
    in_data  = v.pt;
    @(negedge clk);
    key     = ~v.key;
    in_data = ~v.pt;
    chk({tag, " busy in run"}, 128'(busy), 128'd1);
    chk({tag, " in_ready in run"}, 128'(in_ready), 128'd0);
    wait_out(n);
    in_valid = 1'b0;
    chk({tag, " latency"}, 128'(n), 128'd10);
    chk({tag, " ciphertext"}, out_data, v.ct);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " out_valid after retire"}, 128'(out_valid), 128'd0);
    chk({tag, " in_ready after retire"}, 128'(in_ready), 128'd1);
  endtask

  initial begin
    int           n;
    int           cyc, nacc, nout;
    int           acc_cyc [2];
    logic [127:0] got [2];
    logic         acc;

    vecs[0] = {128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
               128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = {128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_data    = '0;
    key        = '0;
    in_valid2  = 1'b0;
    out_ready2 = 1'b0;
    in_data2   = '0;
    key2       = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset in_ready", 128'(in_ready), 128'd1);
    chk("reset out_valid", 128'(out_valid), 128'd0);
    chk("reset out_data", out_data, 128'd0);
    chk("reset busy", 128'(busy), 128'd0);
    chk("reset 256 in_ready", 128'(in_ready2), 128'd1);
    rst_n = 1'b1;

    // Table-driven AES-128 vectors
    for (int i = 0; i < 3; i++) run_block(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: ciphertext held for 5 cycles with out_ready low
    @(negedge clk);
    in_valid = 1'b1;
    key      = vecs[0].key;
    in_data  = vecs[0].pt;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(n);
    chk("bp latency", 128'(n), 128'd10);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp out_valid %0d", i), 128'(out_valid), 128'd1);
      chk($sformatf("bp out_data %0d", i), out_data, vecs[0].ct);
      chk($sformatf("bp in_ready %0d", i), 128'(in_ready), 128'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp out_valid after", 128'(out_valid), 128'd0);
    chk("bp in_ready after", 128'(in_ready), 128'd1);
    chk("bp busy after", 128'(busy), 128'd0);

    // Reset mid-run at rnd=5
    @(negedge clk);
    in_valid = 1'b1;
    key      = vecs[1].key;
    in_data  = vecs[1].pt;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst out_valid", 128'(out_valid), 128'd0);
    chk("midrst out_data", out_data, 128'd0);
    chk("midrst in_ready", 128'(in_ready), 128'd1);
    chk("midrst busy", 128'(busy), 128'd0);
    run_block(vecs[0], "post-reset");

    // Back-to-back with in_valid and out_ready held high
    @(negedge clk);
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    key        = vecs[0].key;
    in_data    = vecs[0].pt;
    cyc        = 0;
    nacc       = 0;
    nout       = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    got[0]     = '0;
    got[1]     = '0;
    while (nout < 2 && cyc < 80) begin
      acc = in_valid && in_ready;
      if (out_valid) begin
        got[nout] = out_data;
        nout++;
      end
      @(negedge clk);
      cyc++;
      if (acc && nacc < 2) begin
        acc_cyc[nacc] = cyc - 1;
        nacc++;
        if (nacc == 1) begin
          key     = vecs[1].key;
          in_data = vecs[1].pt;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b accepts", 128'(nacc), 128'd2);
    chk("b2b spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'(Spacing));
    chk("b2b ct0", got[0], vecs[0].ct);
    chk("b2b ct1", got[1], vecs[1].ct);
    @(negedge clk);
    chk("b2b idle after", 128'(busy), 128'd0);

    // AES-256 vector, latency 14
    in_valid2 = 1'b1;
    key2      = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    in_data2  = 128'h00112233445566778899aabbccddeeff;
    @(negedge clk);
    in_valid2 = 1'b0;
    key2      = '1;
    in_data2  = '1;
    n = 0;
    while (!out_valid2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("aes256 latency", 128'(n), 128'd14);
    chk("aes256 ciphertext", out_data2, 128'h8ea2b7ca516745bfeafc49904b496089);
    out_ready2 = 1'b1;
    @(negedge clk);
    out_ready2 = 1'b0;
    chk("aes256 out_valid after", 128'(out_valid2), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
